// File: rtl/mem_arbiter.sv
// mem_arbiter: shares core memory port A between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data wins over fetch.
module mem_arbiter #(
    parameter int          RD_LATENCY = 1,
    parameter logic [15:0] ADDR_HI    = 16'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wbits,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_wrdata,
    output logic [3:0]  m_wrbits,
    input  logic [31:0] m_rddata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic        own_d, own_d_nx;
    logic        i_ack_nx, i_err_nx, d_ack_nx, d_err_nx;
    logic [31:0] i_rdata_nx, d_rdata_nx;
    logic [31:0] m_address_nx, m_wrdata_nx;
    logic [3:0]  m_wrbits_nx;
    logic        m_read_nx, m_write_nx;
    logic        pri_d, gnt_d, any_req, sel_we, sel_err;
    logic [31:0] sel_addr;

    assign any_req  = i_req | d_req;
    assign gnt_d    = d_req & (~i_req | pri_d);
    assign sel_addr = gnt_d ? d_addr : i_addr;
    assign sel_we   = gnt_d & d_we;
    assign sel_err  = (sel_addr[31:16] != ADDR_HI);

`ifdef MEM_ARB_RR_EN
    // Remembers who was granted last; resets to "fetch last" so data wins the first tie.
    logic last_d;
    always_ff @(posedge clock or negedge reset)
        if (!reset)                       last_d <= 1'b0;
        else if (state == IDLE && any_req) last_d <= gnt_d;
    assign pri_d = ~last_d;
`else
    assign pri_d = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            own_d     <= 1'b0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            m_address <= '0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_wrdata  <= '0;
            m_wrbits  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            own_d     <= own_d_nx;
            i_ack     <= i_ack_nx;
            i_err     <= i_err_nx;
            i_rdata   <= i_rdata_nx;
            d_ack     <= d_ack_nx;
            d_err     <= d_err_nx;
            d_rdata   <= d_rdata_nx;
            m_address <= m_address_nx;
            m_read    <= m_read_nx;
            m_write   <= m_write_nx;
            m_wrdata  <= m_wrdata_nx;
            m_wrbits  <= m_wrbits_nx;
        end
    end

    // Every output is a one-cycle event by default; only a load holds m_read/m_address.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        own_d_nx     = own_d;
        i_ack_nx     = 1'b0;
        i_err_nx     = 1'b0;
        i_rdata_nx   = '0;
        d_ack_nx     = 1'b0;
        d_err_nx     = 1'b0;
        d_rdata_nx   = '0;
        m_address_nx = '0;
        m_read_nx    = 1'b0;
        m_write_nx   = 1'b0;
        m_wrdata_nx  = '0;
        m_wrbits_nx  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    own_d_nx = gnt_d;
                    if (sel_err) begin
                        d_ack_nx = gnt_d;
                        d_err_nx = gnt_d;
                        i_ack_nx = ~gnt_d;
                        i_err_nx = ~gnt_d;
                        state_nx = RESP;
                    end else if (sel_we) begin
                        m_write_nx   = 1'b1;
                        m_address_nx = sel_addr;
                        m_wrdata_nx  = d_wdata;
                        m_wrbits_nx  = d_wbits;
                        state_nx     = WR;
                    end else begin
                        m_read_nx    = 1'b1;
                        m_address_nx = sel_addr;
                        cnt_nx       = 2'(RD_LATENCY);
                        state_nx     = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 2'd0) begin
                    if (own_d) begin
                        d_ack_nx   = 1'b1;
                        d_rdata_nx = m_rddata;
                    end else begin
                        i_ack_nx   = 1'b1;
                        i_rdata_nx = m_rddata;
                    end
                    state_nx = RESP;
                end else begin
                    m_read_nx    = 1'b1;
                    m_address_nx = m_address;
                    cnt_nx       = cnt - 2'd1;
                end
            end
            WR: begin
                d_ack_nx = own_d;
                i_ack_nx = ~own_d;
                state_nx = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule
